// File: rtl/pkt_mux_2_1_pkg.sv
// Shared definitions for the two-source packet mux: FSM encodings and default beat width.
package pkt_mux_2_1_pkg;

  localparam int unsigned DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } state_t;

endpackage

// File: rtl/pkt_mux_2_1_rr_arb_2.sv
// Two-request round-robin arbiter; pointer names the preferred source on a tie.
module rr_arb_2 (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  input  logic upd_en,
  input  logic upd_src,
  output logic gnt0_c,
  output logic gnt1_c,
  output logic ptr
);

  // A grant never looks at its own request, so it cannot loop back through the requester.
  always_comb begin
    gnt0_c = !req1 || !ptr;
    gnt1_c = !req0 || ptr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (upd_en) begin
      ptr <= ~upd_src;
    end
  end

endmodule

// File: rtl/pkt_mux_2_1.sv
// Merges two valid/ready packet streams onto one output without interleaving packets.
module pkt_mux_2_1
  import pkt_mux_2_1_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in0_valid,
  output logic              in0_ready,
  input  logic [DATA_W-1:0] in0_data,
  input  logic              in0_last,
  input  logic              in1_valid,
  output logic              in1_ready,
  input  logic [DATA_W-1:0] in1_data,
  input  logic              in1_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_src,
  output logic [7:0]        pkt_cnt0,
  output logic [7:0]        pkt_cnt1
);

  state_t state_q;
  state_t state_d;
  logic   space_c;
  logic   gnt0_c;
  logic   gnt1_c;
  logic   ptr;
  logic   acc0_c;
  logic   acc1_c;
  logic   acc_c;
  logic   acc_last_c;

  assign space_c    = !out_valid || out_ready;
  assign acc0_c     = in0_valid && in0_ready;
  assign acc1_c     = in1_valid && in1_ready;
  assign acc_c      = acc0_c || acc1_c;
  assign acc_last_c = acc1_c ? in1_last : in0_last;

  rr_arb_2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req0    (in0_valid),
    .req1    (in1_valid),
    .upd_en  (acc_c && acc_last_c),
    .upd_src (acc1_c),
    .gnt0_c  (gnt0_c),
    .gnt1_c  (gnt1_c),
    .ptr     (ptr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Lock onto a source on a non-final beat; release when its final beat is taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (acc_c && !acc_last_c) begin
          state_d = acc1_c ? ST_LOCK1 : ST_LOCK0;
        end
      end
      ST_LOCK0: begin
        if (acc0_c && in0_last) begin
          state_d = ST_IDLE;
        end
      end
      ST_LOCK1: begin
        if (acc1_c && in1_last) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Ready is held low while reset is asserted even though the output register is empty.
  always_comb begin
    in0_ready = 1'b0;
    in1_ready = 1'b0;
    if (rst_n && space_c) begin
      case (state_q)
        ST_IDLE: begin
          in0_ready = gnt0_c;
          in1_ready = gnt1_c;
        end
        ST_LOCK0: in0_ready = 1'b1;
        ST_LOCK1: in1_ready = 1'b1;
        default: begin
          in0_ready = 1'b0;
          in1_ready = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_src   <= 1'b0;
    end else if (space_c) begin
      out_valid <= acc_c;
      if (acc_c) begin
        out_data <= acc1_c ? in1_data : in0_data;
        out_last <= acc_last_c;
        out_src  <= acc1_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt0 <= 8'd0;
      pkt_cnt1 <= 8'd0;
    end else begin
      if (acc0_c && in0_last) pkt_cnt0 <= pkt_cnt0 + 8'd1;
      if (acc1_c && in1_last) pkt_cnt1 <= pkt_cnt1 + 8'd1;
    end
  end

endmodule

// File: tb/tb_pkt_mux_2_1.sv
// Directed self-checking bench for pkt_mux_2_1.
module tb_pkt_mux_2_1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in0_valid = 1'b0, in0_last = 1'b0, in0_ready;
  logic       in1_valid = 1'b0, in1_last = 1'b0, in1_ready;
  logic [7:0] in0_data = 8'h00, in1_data = 8'h00;
  logic       out_valid, out_last, out_src;
  logic       out_ready = 1'b0;
  logic [7:0] out_data, pkt_cnt0, pkt_cnt1;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  pkt_mux_2_1 #(.DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_data(in0_data), .in0_last(in0_last),
    .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_data(in1_data), .in1_last(in1_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .out_src(out_src), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    in0_valid = 1'b0; in1_valid = 1'b0; in0_last = 1'b0; in1_last = 1'b0;
    in0_data = 8'h00; in1_data = 8'h00; out_ready = 1'b1; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in0_valid = 1'b1; in1_valid = 1'b1; out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b exp 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL rst_out_data: got %h exp 00", out_data); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last: got %b exp 0", out_last); end
    checks++; if (out_src !== 1'b0) begin errors++; $display("FAIL rst_out_src: got %b exp 0", out_src); end
    checks++; if (pkt_cnt0 !== 8'd0 || pkt_cnt1 !== 8'd0) begin errors++; $display("FAIL rst_cnt: got %0d/%0d exp 0/0", pkt_cnt0, pkt_cnt1); end
    checks++; if (in0_ready !== 1'b0 || in1_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b/%b exp 0/0", in0_ready, in1_ready); end
    in0_valid = 1'b0; in1_valid = 1'b0; rst_n = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_idle_valid: got %b exp 0", out_valid); end
  endtask

  task automatic test_alternate();
    logic [7:0] exp_d;
    apply_reset();
    in0_valid = 1'b1; in1_valid = 1'b1; in0_last = 1'b1; in1_last = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in0_data = 8'hA0 + 8'(k / 2);
      in1_data = 8'hB0 + 8'(k / 2);
      exp_d = ((k % 2) == 0) ? (8'hA0 + 8'(k / 2)) : (8'hB0 + 8'(k / 2));
      #1;
      checks++; if (in0_ready !== 1'((k + 1) % 2) || in1_ready !== 1'(k % 2)) begin errors++; $display("FAIL alt_ready k=%0d: got %b/%b", k, in0_ready, in1_ready); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_data !== exp_d || out_src !== 1'(k % 2) || out_last !== 1'b1) begin
        errors++; $display("FAIL alt_out k=%0d: got v%b d%h s%b l%b exp v1 d%h s%0d l1", k, out_valid, out_data, out_src, out_last, exp_d, k % 2);
      end
    end
    in0_valid = 1'b0; in1_valid = 1'b0;
    checks++; if (pkt_cnt0 !== 8'd2 || pkt_cnt1 !== 8'd2) begin errors++; $display("FAIL alt_cnt: got %0d/%0d exp 2/2", pkt_cnt0, pkt_cnt1); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL alt_drain: got %b exp 0", out_valid); end
  endtask

  task automatic test_lock();
    logic [7:0] bd [3];
    bd = '{8'h11, 8'h12, 8'h13};
    apply_reset();
    in1_valid = 1'b1; in1_data = 8'h31; in1_last = 1'b1; in0_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in0_data = bd[i]; in0_last = (i == 2);
      #1;
      checks++; if (in0_ready !== 1'b1 || in1_ready !== 1'b0) begin errors++; $display("FAIL lock_ready i=%0d: got %b/%b exp 1/0", i, in0_ready, in1_ready); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_data !== bd[i] || out_src !== 1'b0 || out_last !== (i == 2)) begin
        errors++; $display("FAIL lock_out i=%0d: got v%b d%h s%b l%b exp d%h s0", i, out_valid, out_data, out_src, out_last, bd[i]);
      end
    end
    in0_valid = 1'b0;
    #1;
    checks++; if (in1_ready !== 1'b1) begin errors++; $display("FAIL lock_rel_ready: got %b exp 1", in1_ready); end
    tick();
    in1_valid = 1'b0;
    checks++; if (out_data !== 8'h31 || out_src !== 1'b1 || out_valid !== 1'b1) begin errors++; $display("FAIL lock_in1_out: got d%h s%b v%b exp d31 s1 v1", out_data, out_src, out_valid); end
    checks++; if (pkt_cnt0 !== 8'd1 || pkt_cnt1 !== 8'd1) begin errors++; $display("FAIL lock_cnt: got %0d/%0d exp 1/1", pkt_cnt0, pkt_cnt1); end
  endtask

  task automatic test_stall();
    apply_reset();
    in0_valid = 1'b1; in0_data = 8'h5C; in0_last = 1'b1;
    tick();
    out_ready = 1'b0; in0_data = 8'h77; in1_valid = 1'b1; in1_data = 8'h88; in1_last = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (in0_ready !== 1'b0 || in1_ready !== 1'b0) begin errors++; $display("FAIL stall_ready c=%0d: got %b/%b exp 0/0", c, in0_ready, in1_ready); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_data !== 8'h5C || out_src !== 1'b0 || out_last !== 1'b1) begin
        errors++; $display("FAIL stall_hold c=%0d: got v%b d%h s%b l%b exp v1 d5c s0 l1", c, out_valid, out_data, out_src, out_last);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h5C) begin errors++; $display("FAIL stall_release_out: got v%b d%h exp v1 d5c", out_valid, out_data); end
    checks++; if (in0_ready !== 1'b0 || in1_ready !== 1'b1) begin errors++; $display("FAIL stall_ptr_ready: got %b/%b exp 0/1", in0_ready, in1_ready); end
    tick();
    in0_valid = 1'b0; in1_valid = 1'b0;
    checks++; if (out_data !== 8'h88 || out_src !== 1'b1) begin errors++; $display("FAIL stall_next: got d%h s%b exp d88 s1", out_data, out_src); end
  endtask

  task automatic test_gap();
    apply_reset();
    in1_valid = 1'b1; in1_data = 8'h21; in1_last = 1'b0;
    tick();
    checks++; if (out_data !== 8'h21 || out_src !== 1'b1 || out_last !== 1'b0) begin errors++; $display("FAIL gap_first: got d%h s%b l%b exp d21 s1 l0", out_data, out_src, out_last); end
    in1_valid = 1'b0; in0_valid = 1'b1; in0_data = 8'h99; in0_last = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (in0_ready !== 1'b0) begin errors++; $display("FAIL gap_in0_ready c=%0d: got %b exp 0", c, in0_ready); end
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL gap_idle_out c=%0d: got %b exp 0", c, out_valid); end
    end
    in1_valid = 1'b1; in1_data = 8'h22; in1_last = 1'b1;
    #1;
    checks++; if (in0_ready !== 1'b0 || in1_ready !== 1'b1) begin errors++; $display("FAIL gap_last_ready: got %b/%b exp 0/1", in0_ready, in1_ready); end
    tick();
    checks++; if (out_data !== 8'h22 || out_src !== 1'b1 || out_last !== 1'b1) begin errors++; $display("FAIL gap_last_out: got d%h s%b l%b exp d22 s1 l1", out_data, out_src, out_last); end
    in1_data = 8'h23;
    #1;
    checks++; if (in0_ready !== 1'b1 || in1_ready !== 1'b0) begin errors++; $display("FAIL gap_ptr0: got %b/%b exp 1/0", in0_ready, in1_ready); end
    tick();
    in0_valid = 1'b0; in1_valid = 1'b0;
    checks++; if (out_data !== 8'h99 || out_src !== 1'b0) begin errors++; $display("FAIL gap_after: got d%h s%b exp d99 s0", out_data, out_src); end
    checks++; if (pkt_cnt1 !== 8'd1) begin errors++; $display("FAIL gap_cnt1: got %0d exp 1", pkt_cnt1); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    in0_valid = 1'b1; in0_data = 8'h40; in0_last = 1'b1;
    tick();
    in0_data = 8'h41; in0_last = 1'b0;
    tick();
    checks++; if (pkt_cnt0 !== 8'd1 || out_data !== 8'h41 || out_valid !== 1'b1) begin errors++; $display("FAIL arst_pre: got c%0d d%h v%b exp c1 d41 v1", pkt_cnt0, out_data, out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || pkt_cnt0 !== 8'd0 || out_data !== 8'h00) begin errors++; $display("FAIL arst_clear: got v%b c%0d d%h exp v0 c0 d00", out_valid, pkt_cnt0, out_data); end
    in0_valid = 1'b0;
    #1;
    rst_n = 1'b1;
    in1_valid = 1'b1; in1_data = 8'h51; in1_last = 1'b1;
    #1;
    checks++; if (in1_ready !== 1'b1) begin errors++; $display("FAIL arst_in1_ready: got %b exp 1", in1_ready); end
    tick();
    in1_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h51 || out_src !== 1'b1) begin errors++; $display("FAIL arst_in1_out: got v%b d%h s%b exp v1 d51 s1", out_valid, out_data, out_src); end
    checks++; if (pkt_cnt1 !== 8'd1 || pkt_cnt0 !== 8'd0) begin errors++; $display("FAIL arst_cnt: got %0d/%0d exp 0/1", pkt_cnt0, pkt_cnt1); end
  endtask

  task automatic test_wrap();
    apply_reset();
    in0_valid = 1'b1; in0_last = 1'b1;
    for (int i = 0; i < 256; i++) begin
      in0_data = 8'(i);
      tick();
      if (i == 0) begin
        checks++; if (pkt_cnt0 !== 8'd1) begin errors++; $display("FAIL wrap_first: got %0d exp 1", pkt_cnt0); end
      end
      if (i == 254) begin
        checks++; if (pkt_cnt0 !== 8'd255) begin errors++; $display("FAIL wrap_255: got %0d exp 255", pkt_cnt0); end
      end
    end
    in0_valid = 1'b0;
    checks++; if (pkt_cnt0 !== 8'd0 || pkt_cnt1 !== 8'd0) begin errors++; $display("FAIL wrap_zero: got %0d/%0d exp 0/0", pkt_cnt0, pkt_cnt1); end
    checks++; if (out_data !== 8'hFF || out_src !== 1'b0) begin errors++; $display("FAIL wrap_last_beat: got d%h s%b exp dff s0", out_data, out_src); end
  endtask

  initial begin
    test_reset();
    test_alternate();
    test_lock();
    test_stall();
    test_gap();
    test_async_reset();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pkt_mux_2_1.md
PKT_MUX_2_1 -- requirements
Module: pkt_mux_2_1

Interface
REQ-001 Parameter DATA_W, default 8, width of each data beat.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous reset, active-low; asserted clears state immediately, deasserted synchronously to clk.
REQ-004 in0_valid  input  1  source 0 beat present.
REQ-005 in0_ready  output  1  source 0 beat accepted this cycle when high with in0_valid.
REQ-006 in0_data  input  DATA_W  source 0 beat payload.
REQ-007 in0_last  input  1  source 0 beat is final beat of packet.
REQ-008 in1_valid, in1_ready, in1_data, in1_last  same directions, widths and meaning for source 1.
REQ-009 out_valid  output  1  merged beat present.
REQ-010 out_ready  input  1  sink accepts beat.
REQ-011 out_data  output  DATA_W  merged beat payload.
REQ-012 out_last  output  1  final beat of packet.
REQ-013 out_src  output  1  originating source (0/1) of current beat.
REQ-014 pkt_cnt0, pkt_cnt1  output  8 each  completed-packet counts per source, wrap 255->0.

Function
REQ-015 Block SHALL merge two packet streams into one, never interleaving beats of different packets.
REQ-016 FSM states IDLE, LOCK0, LOCK1.
REQ-017 Output register "space" = !out_valid || out_ready.
REQ-018 IDLE: winner = only valid source; both valid -> source at priority pointer; inX_ready = space && winner==X; neither valid -> no ready.
REQ-019 IDLE, accepted beat last=1: stay IDLE, pointer <= ~src, pkt_cntX +1.
REQ-020 IDLE, accepted beat last=0: go LOCKX.
REQ-021 LOCKX: inX_ready = space; other input ready held 0 regardless of its valid.
REQ-022 LOCKX, accepted beat last=1: go IDLE, pointer <= ~X, pkt_cntX +1; else stay LOCKX.
REQ-023 Latency: beat accepted in cycle N appears on out_* at cycle N+1.
REQ-024 Throughput: one beat/cycle sustained while out_ready high, including back-to-back packets alternating sources.
REQ-025 out_valid/out_data/out_last/out_src SHALL be held stable while out_valid && !out_ready.
REQ-026 inX_ready SHALL NOT depend combinationally on inX_valid; in IDLE it may depend on the other source's valid.
REQ-027 Source valid dropping mid-packet in LOCKX: stay LOCKX, emit nothing, wait.
REQ-028 out_ready low with register full: both in*_ready low, state and pointer unchanged.
REQ-029 Counter wrap: pkt_cntX at 255 and packet completes -> 0, no flag.

Reset
REQ-030 rst_n low: state IDLE, pointer 0, out_valid 0, out_data 0, out_last 0, out_src 0, pkt_cnt0/1 0, in*_ready 0.
REQ-031 Reset mid-packet SHALL discard the registered beat and partial packet; no resumption after release.
REQ-032 First edge after rst_n release SHALL behave as IDLE with pointer 0.

Structure
REQ-033 Shared header SHALL hold FSM state encodings and DATA_W default; no other constants.
REQ-034 One sub-module rr_arb_2 (2-request round-robin arbiter with pointer update enable) SHALL implement REQ-018/019/022 pointer logic.
REQ-035 Output register and FSM SHALL live in pkt_mux_2_1; no other hierarchy.

Verification
REQ-036 Both valid, single-beat, out_ready=1, in0_data=0xA0.., in1_data=0xB0.. -> out order A0,B0,A1,B1 one per cycle, out_src 0,1,0,1.
REQ-037 in0 3-beat packet (11,12,13 last) with in1 valid throughout -> out 11,12,13 src0 then in1 beats; in1_ready 0 during LOCK0; pkt_cnt0=1.
REQ-038 out_ready=0 for 4 cycles with out_valid=1, out_data=0x5C -> out_* stable, in*_ready 0, then 0x5C consumed on first out_ready=1 cycle.
REQ-039 LOCK1 after beat 0x21, in1_valid low 3 cycles then 0x22 last -> no out beats during gap, in0 ignored, return to IDLE pointer 0.
REQ-040 rst_n pulsed low mid-packet (async, between edges) -> out_valid 0 immediately, counters 0, next packet from in1 alone accepted from IDLE.
REQ-041 256 single-beat packets on in0 -> pkt_cnt0 returns to 0, pkt_cnt1 unchanged.
